// File: rtl/add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package add_sub_pkg;

    // Controller states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // Operation select values for the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// Combinational full-adder cell built from two half adders plus an OR on the carries.

module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s1;
    logic c1;
    logic c2;

    // First half adder combines the operand bits.
    ha_cell u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    // Second half adder folds in the incoming carry.
    ha_cell u_ha1 (
        .a (s1),
        .b (cin),
        .s (s),
        .c (c2)
    );

    // At most one of the two half adders can generate a carry.
    assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial W-bit adder/subtractor. Operands are loaded in parallel on start,
// fed LSB first through one full-adder cell with a carry flip-flop, and the
// sum is collected in a shift register. Subtraction is a + ~b + 1, with the
// +1 injected through the initial carry.
// Optional build macro: SIGNED_OVF_EN adds the ovf output (signed overflow).
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout
`ifdef SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]       opa_q,   opa_d;
    logic [W-1:0]       opb_q,   opb_d;
    logic [W-1:0]       res_q,   res_d;
    logic               carry_q, carry_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic               cout_q,  cout_d;
`ifdef SIGNED_OVF_EN
    logic               ovf_q,   ovf_d;
`endif

    logic fa_s;
    logic fa_co;

    // Single full-adder cell processes the current LSB pair with the stored carry.
    fa_cell u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Next-state logic: load on accepted start, shift one bit per cycle, then report.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    opa_d   = a;
                    opb_d   = (sub == OP_SUB) ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_SHIFT: begin
                carry_d = fa_co;
                res_d   = {fa_s, res_q[W-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W - 1)) begin
                    // This cycle handles the MSB; the carry into it is carry_q.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
`ifdef SIGNED_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                cout_d  = carry_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state and registered outputs; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign cout   = cout_q;
`ifdef SIGNED_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub with W=8.
// Optional build macro: SIGNED_OVF_EN enables the ovf checks.
module tb_serial_add_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       ovf_obs;
`ifdef SIGNED_OVF_EN
    logic       ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    int tests;
    int fails;

    serial_add_sub #(.W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SIGNED_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from a point just after a rising edge. Optionally
    // pulse start again (with other operands) before edge inj_at. Returns the
    // edge number (relative to the accepting edge 0) at which done was seen,
    // or 0 on timeout, plus the number of busy cycles before done.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                          input int inj_at, input logic [7:0] ja, input logic [7:0] jb,
                          output int done_cyc, output int busy_cnt,
                          output logic [7:0] r, output logic c, output logic v);
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hA5; b = 8'h5A; sub = ~isub;
        busy_cnt = int'(busy);
        done_cyc = 0; r = 8'h00; c = 1'b0; v = 1'b0;
        for (int i = 1; i <= 14 && done_cyc == 0; i++) begin
            if (i == inj_at) begin
                start = 1'b1; a = ja; b = jb;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                done_cyc = i; r = result; c = cout; v = ovf_obs;
            end else begin
                busy_cnt += int'(busy);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00;
        #1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (result !== 8'h00)  begin fails++; $display("FAIL reset_result got=%h exp=00", result); end
        tests++; if (cout !== 1'b0)     begin fails++; $display("FAIL reset_cout got=%b exp=0", cout); end
        tests++; if (ovf_obs !== 1'b0)  begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf_obs); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int dc, bc; logic [7:0] r; logic c, v;
        run_op(8'h35, 8'h4A, 1'b0, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (dc != 9)     begin fails++; $display("FAIL add1_latency got=%0d exp=9", dc); end
        tests++; if (bc != 8)     begin fails++; $display("FAIL add1_busy_cycles got=%0d exp=8", bc); end
        tests++; if (r !== 8'h7F) begin fails++; $display("FAIL add1_result got=%h exp=7f", r); end
        tests++; if (c !== 1'b0)  begin fails++; $display("FAIL add1_cout got=%b exp=0", c); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL add1_done_pulse got=%b exp=0", done); end
        tests++; if (result !== 8'h7F)  begin fails++; $display("FAIL add1_result_hold got=%h exp=7f", result); end
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL add1_idle_busy got=%b exp=0", busy); end

        run_op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (dc != 9)     begin fails++; $display("FAIL add2_latency got=%0d exp=9", dc); end
        tests++; if (r !== 8'h00) begin fails++; $display("FAIL add2_result got=%h exp=00", r); end
        tests++; if (c !== 1'b1)  begin fails++; $display("FAIL add2_cout got=%b exp=1", c); end
`ifdef SIGNED_OVF_EN
        tests++; if (v !== 1'b0)  begin fails++; $display("FAIL add2_ovf got=%b exp=0", v); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int dc, bc; logic [7:0] r; logic c, v;
        run_op(8'h10, 8'h01, 1'b1, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (dc != 9)     begin fails++; $display("FAIL sub1_latency got=%0d exp=9", dc); end
        tests++; if (r !== 8'h0F) begin fails++; $display("FAIL sub1_result got=%h exp=0f", r); end
        tests++; if (c !== 1'b1)  begin fails++; $display("FAIL sub1_cout got=%b exp=1", c); end
        @(posedge clk); #1;
        run_op(8'h00, 8'h01, 1'b1, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (r !== 8'hFF) begin fails++; $display("FAIL sub2_result got=%h exp=ff", r); end
        tests++; if (c !== 1'b0)  begin fails++; $display("FAIL sub2_cout got=%b exp=0", c); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int dc, bc; logic [7:0] r; logic c, v;
        run_op(8'h7F, 8'h01, 1'b0, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (r !== 8'h80) begin fails++; $display("FAIL ovf_add_result got=%h exp=80", r); end
        tests++; if (c !== 1'b0)  begin fails++; $display("FAIL ovf_add_cout got=%b exp=0", c); end
`ifdef SIGNED_OVF_EN
        tests++; if (v !== 1'b1)  begin fails++; $display("FAIL ovf_add_flag got=%b exp=1", v); end
`endif
        @(posedge clk); #1;
        run_op(8'h80, 8'h01, 1'b1, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (r !== 8'h7F) begin fails++; $display("FAIL ovf_sub_result got=%h exp=7f", r); end
        tests++; if (c !== 1'b1)  begin fails++; $display("FAIL ovf_sub_cout got=%b exp=1", c); end
`ifdef SIGNED_OVF_EN
        tests++; if (v !== 1'b1)  begin fails++; $display("FAIL ovf_sub_flag got=%b exp=1", v); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int dc, bc; logic [7:0] r; logic c, v;
        // Start pulsed mid-operation with different operands.
        run_op(8'h12, 8'h34, 1'b0, 3, 8'hFF, 8'hFF, dc, bc, r, c, v);
        tests++; if (dc != 9)     begin fails++; $display("FAIL ign_busy_latency got=%0d exp=9", dc); end
        tests++; if (r !== 8'h46) begin fails++; $display("FAIL ign_busy_result got=%h exp=46", r); end
        tests++; if (c !== 1'b0)  begin fails++; $display("FAIL ign_busy_cout got=%b exp=0", c); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_busy_no_restart got=%b exp=0", busy); end
        // Start pulsed while the controller is in its report state.
        run_op(8'h01, 8'h02, 1'b0, 9, 8'h40, 8'h40, dc, bc, r, c, v);
        tests++; if (r !== 8'h03) begin fails++; $display("FAIL ign_done_result got=%h exp=03", r); end
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL ign_done_no_restart got=%b exp=0", busy); end
        tests++; if (result !== 8'h03) begin fails++; $display("FAIL ign_done_hold got=%h exp=03", result); end
    endtask

    task automatic test_back_to_back();
        int dc, bc; logic [7:0] r; logic c, v;
        run_op(8'hC8, 8'h64, 1'b0, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (r !== 8'h2C) begin fails++; $display("FAIL b2b_first_result got=%h exp=2c", r); end
        tests++; if (c !== 1'b1)  begin fails++; $display("FAIL b2b_first_cout got=%b exp=1", c); end
        // Next start issued during the done pulse cycle.
        run_op(8'h64, 8'hC8, 1'b1, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (dc != 9)     begin fails++; $display("FAIL b2b_second_latency got=%0d exp=9", dc); end
        tests++; if (r !== 8'h9C) begin fails++; $display("FAIL b2b_second_result got=%h exp=9c", r); end
        tests++; if (c !== 1'b0)  begin fails++; $display("FAIL b2b_second_cout got=%b exp=0", c); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dc, bc; logic [7:0] r; logic c, v;
        int seen_done;
        start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL rstmid_done got=%b exp=0", done); end
        tests++; if (result !== 8'h00) begin fails++; $display("FAIL rstmid_result got=%h exp=00", result); end
        tests++; if (cout !== 1'b0)    begin fails++; $display("FAIL rstmid_cout got=%b exp=0", cout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        tests++; if (seen_done != 0) begin fails++; $display("FAIL rstmid_no_done got=%0d exp=0", seen_done); end
        run_op(8'h10, 8'h01, 1'b1, 0, 8'h00, 8'h00, dc, bc, r, c, v);
        tests++; if (dc != 9)     begin fails++; $display("FAIL rstmid_after_latency got=%0d exp=9", dc); end
        tests++; if (r !== 8'h0F) begin fails++; $display("FAIL rstmid_after_result got=%h exp=0f", r); end
        tests++; if (c !== 1'b1)  begin fails++; $display("FAIL rstmid_after_cout got=%b exp=1", c); end
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
